// File: rtl/spi_frame_scheduler_pkg.sv
// Shared state encoding, default timings and a sizing helper for the SPI frame scheduler.
package spi_frame_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_GAP   = 3'd5
   } state_e;

   localparam int DEF_NREQ        = 2;
   localparam int DEF_SETUP_CYC   = 4;
   localparam int DEF_GAP_CYC     = 16;
   localparam int DEF_TIMEOUT_CYC = 4096;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_frame_scheduler_if.sv
// Requester byte streams plus SPI engine handshake, as seen by the scheduler (slave side).
interface spi_frame_scheduler_if #(
   parameter int NREQ = spi_frame_scheduler_pkg::DEF_NREQ
);
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic              spi_wr;
   logic [7:0]        spi_data;
   logic              spi_done;
   logic              spi_cs_n;
   logic [NREQ-1:0]   grant;
   logic              busy;
   logic              timeout_err;

   modport slave (
      input  req_valid, req_data, req_last, spi_done,
      output req_ready, spi_wr, spi_data, spi_cs_n, grant, busy, timeout_err
   );

   modport master (
      output req_valid, req_data, req_last, spi_done,
      input  req_ready, spi_wr, spi_data, spi_cs_n, grant, busy, timeout_err
   );
endinterface

// File: rtl/spi_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, returned one-hot.
module rr_arbiter
   import spi_frame_scheduler_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   output logic [NREQ-1:0]         gnt_o
);
   logic [NREQ-1:0] req_rot;
   logic [NREQ-1:0] gnt_rot;

   // Rotate so ptr_i sits at bit 0, isolate the lowest set bit, rotate back.
   always_comb begin
      req_rot = NREQ'({req_i, req_i} >> ptr_i);
      gnt_rot = req_rot & (~req_rot + NREQ'(1));
      gnt_o   = NREQ'(({gnt_rot, gnt_rot} << ptr_i) >> NREQ);
   end
endmodule

// File: rtl/spi_frame_scheduler.sv
// Round-robin framing of NREQ byte streams onto one single-byte SPI engine, with timeout abort.
module spi_frame_scheduler
   import spi_frame_scheduler_pkg::*;
#(
   parameter int NREQ        = DEF_NREQ,
   parameter int SETUP_CYC   = DEF_SETUP_CYC,
   parameter int GAP_CYC     = DEF_GAP_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input logic                   clk,
   input logic                   rst,
   spi_frame_scheduler_if.slave  bus
);
   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(max3(SETUP_CYC, GAP_CYC, TIMEOUT_CYC)) + 1;

   state_e            state_q, state_d;
   logic [NREQ-1:0]   grant_q, grant_d, arb_gnt, ready;
   logic [PW-1:0]     rr_q, rr_d, grant_idx;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [7:0]        data_q, data_d, sel_data;
   logic              last_q, last_d, wr_q, wr_d, cs_n_q, cs_n_d, terr_q, terr_d;
   logic              done_prev_q, byte_done, sel_valid, sel_last;
   logic [7:0][NREQ-1:0]    data_cols;
   logic [PW-1:0][NREQ-1:0] idx_cols;

   rr_arbiter #(.NREQ(NREQ)) u_arb (.req_i(bus.req_valid), .ptr_i(rr_q), .gnt_o(arb_gnt));

   // AND-OR mux of the granted requester's byte, plus binary index of the grant.
   generate
      for (genvar bi = 0; bi < 8; bi++) begin : g_data_bit
         for (genvar gi = 0; gi < NREQ; gi++) begin : g_data_req
            assign data_cols[bi][gi] = bus.req_data[8*gi + bi] & grant_q[gi];
         end
         assign sel_data[bi] = |data_cols[bi];
      end
      for (genvar bi = 0; bi < PW; bi++) begin : g_idx_bit
         for (genvar gi = 0; gi < NREQ; gi++) begin : g_idx_req
            assign idx_cols[bi][gi] = grant_q[gi] & (((gi >> bi) & 1) != 0);
         end
         assign grant_idx[bi] = |idx_cols[bi];
      end
   endgenerate

   assign sel_valid = |(bus.req_valid & grant_q);
   assign sel_last  = |(bus.req_last & grant_q);
   assign byte_done = bus.spi_done & ~done_prev_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      last_d  = last_q;
      cs_n_d  = cs_n_q;
      wr_d    = 1'b0;
      terr_d  = 1'b0;
      ready   = '0;
      case (state_q)
         ST_IDLE: begin
            if (|bus.req_valid) begin
               grant_d = arb_gnt;
               cs_n_d  = 1'b0;
               cnt_d   = CW'(SETUP_CYC - 1);
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) state_d = ST_ISSUE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         ST_ISSUE: begin
            if (sel_valid) begin
               ready   = grant_q;
               data_d  = sel_data;
               last_d  = sel_last;
               wr_d    = 1'b1;
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Completion is tested first so it wins over a coincident terminal count.
            if (byte_done) begin
               if (last_q) begin
                  cs_n_d  = 1'b1;
                  cnt_d   = CW'(GAP_CYC - 1);
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_ISSUE;
               end
            end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               terr_d = 1'b1;
               cs_n_d = 1'b1;
               if (last_q) begin
                  cnt_d   = CW'(GAP_CYC - 1);
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DRAIN: begin
            if (sel_valid) begin
               ready = grant_q;
               if (sel_last) begin
                  cnt_d   = CW'(GAP_CYC - 1);
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               grant_d = '0;
               rr_d    = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         rr_q        <= '0;
         cnt_q       <= '0;
         data_q      <= '0;
         last_q      <= 1'b0;
         wr_q        <= 1'b0;
         cs_n_q      <= 1'b1;
         terr_q      <= 1'b0;
         done_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_q        <= rr_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         last_q      <= last_d;
         wr_q        <= wr_d;
         cs_n_q      <= cs_n_d;
         terr_q      <= terr_d;
         done_prev_q <= bus.spi_done;
      end
   end

   assign bus.req_ready   = ready;
   assign bus.spi_wr      = wr_q;
   assign bus.spi_data    = data_q;
   assign bus.spi_cs_n    = cs_n_q;
   assign bus.grant       = grant_q;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Directed bench: requester queues and an SPI engine model drive the scheduler; frames are logged and checked.
module tb_spi_frame_scheduler;
   localparam int NREQ  = 2;
   localparam int SETUP = 4;
   localparam int GAP   = 16;
   localparam int TMO   = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   spi_frame_scheduler_if #(.NREQ(NREQ)) bus();

   spi_frame_scheduler #(
      .NREQ(NREQ), .SETUP_CYC(SETUP), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   logic [8:0]      q0[$];
   logic [8:0]      q1[$];
   bit              hold0 = 0, hold1 = 0, acc0 = 0, acc1 = 0, prev_cs = 1;
   int              cyc = 0;
   int              done_lat = 4, drop_idx = -1, pend = 0, wr_n = 0;
   bit              level = 0;
   logic [7:0]      wr_log[$];
   int              wr_cyc[$];
   int              cs_fall[$];
   int              cs_rise[$];
   logic [NREQ-1:0] gr_log[$];
   int              terr_n = 0, terr_cyc = 0, acc_n = 0, viol = 0;

   // Requesters, SPI engine model and monitors, all on the falling edge.
   initial begin
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.spi_done  = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (acc0 && q0.size() > 0) void'(q0.pop_front());
         if (acc1 && q1.size() > 0) void'(q1.pop_front());
         if (!level && bus.spi_done) bus.spi_done = 1'b0;
         if (bus.spi_wr) begin
            wr_log.push_back(bus.spi_data);
            wr_cyc.push_back(cyc);
            if (bus.spi_cs_n) viol++;
            if (level) bus.spi_done = 1'b0;
            pend = (wr_n == drop_idx) ? 0 : done_lat;
            wr_n++;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) bus.spi_done = 1'b1;
         end
         if (prev_cs && !bus.spi_cs_n) begin
            cs_fall.push_back(cyc);
            gr_log.push_back(bus.grant);
         end
         if (!prev_cs && bus.spi_cs_n) cs_rise.push_back(cyc);
         prev_cs = bus.spi_cs_n;
         if (bus.timeout_err) begin
            terr_n++;
            terr_cyc = cyc;
         end
         bus.req_valid[0] = (q0.size() > 0) && !hold0;
         bus.req_valid[1] = (q1.size() > 0) && !hold1;
         if (q0.size() > 0) begin
            bus.req_last[0]    = q0[0][8];
            bus.req_data[7:0]  = q0[0][7:0];
         end
         if (q1.size() > 0) begin
            bus.req_last[1]    = q1[0][8];
            bus.req_data[15:8] = q1[0][7:0];
         end
         #1;
         acc0 = bus.req_ready[0];
         acc1 = bus.req_ready[1];
         if ((bus.req_ready & ~(bus.req_valid & bus.grant)) != '0) viol++;
         if (acc0) acc_n++;
         if (acc1) acc_n++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic clear_logs();
      wr_log.delete(); wr_cyc.delete(); cs_fall.delete(); cs_rise.delete(); gr_log.delete();
      wr_n = 0; terr_n = 0; acc_n = 0; viol = 0; pend = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      q0.delete(); q1.delete();
      hold0 = 0; hold1 = 0;
      @(posedge clk); #1;
      chk("rst_cs_n",  bus.spi_cs_n, 1);
      chk("rst_wr",    bus.spi_wr, 0);
      chk("rst_grant", bus.grant, 0);
      chk("rst_busy",  bus.busy, 0);
      chk("rst_data",  bus.spi_data, 0);
      chk("rst_terr",  bus.timeout_err, 0);
      chk("rst_ready", bus.req_ready, 0);
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic load(input int r, input int n, input logic [31:0] bytes);
      logic [8:0] e;
      for (int k = 0; k < n; k++) begin
         e = {k == n - 1, bytes[8*k +: 8]};
         if (r == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   task automatic wait_idle(input string nm, input int maxc);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while ((q0.size() != 0 || q1.size() != 0 || bus.busy) && n < maxc);
      chk(nm, {30'd0, q0.size() != 0 || q1.size() != 0, bus.busy}, 0);
   endtask

   task automatic wait_wr(input string nm, input int cnt, input int maxc);
      int n = 0;
      while (wr_n < cnt && n < maxc) begin
         @(posedge clk); #1;
         n++;
      end
      chk(nm, wr_n, cnt);
   endtask

   typedef struct {
      int          r;
      int          n;
      logic [31:0] bytes;
      int          lat;
      bit          level;
      int          drop;
      int          exp_wr;
      int          exp_terr;
      int          exp_acc;
      int          rise_off;
   } vec_t;

   vec_t       vt[8];
   vec_t       cur;
   logic [7:0] exp2[4];

   initial begin
      // rise_off: cycles from the last spi_wr to cs_n high (done latency + 1, or TMO on timeout).
      vt[0] = '{0, 3, 32'h00FF3CA5, 20,      1'b0, -1, 3, 0, 3, 21};
      vt[1] = '{0, 1, 32'h0000005A, 1,       1'b0, -1, 1, 0, 1, 2};
      vt[2] = '{0, 4, 32'h78563412, 5,       1'b1, -1, 4, 0, 4, 6};
      vt[3] = '{0, 4, 32'hDDCCBBAA, 3,       1'b0, 1,  2, 1, 4, TMO};
      vt[4] = '{0, 2, 32'h00009966, 3,       1'b0, 1,  2, 1, 2, TMO};
      vt[5] = '{1, 2, 32'h0000C3E7, 2,       1'b0, -1, 2, 0, 2, 3};
      vt[6] = '{0, 1, 32'h00000081, TMO - 1, 1'b0, -1, 1, 0, 1, TMO};
      vt[7] = '{0, 1, 32'h00000042, TMO,     1'b0, -1, 1, 1, 1, TMO};

      for (int v = 0; v < 8; v++) begin
         cur = vt[v];
         do_reset();
         done_lat = cur.lat; level = cur.level; drop_idx = cur.drop;
         load(cur.r, cur.n, cur.bytes);
         wait_idle("vec_idle", 3000);
         chk("vec_wr_count", wr_log.size(), cur.exp_wr);
         for (int k = 0; k < wr_log.size() && k < cur.exp_wr; k++)
            chk("vec_wr_data", wr_log[k], cur.bytes[8*k +: 8]);
         chk("vec_terr", terr_n, cur.exp_terr);
         chk("vec_accepts", acc_n, cur.exp_acc);
         chk("vec_viol", viol, 0);
         chk("vec_cs_fall", cs_fall.size(), 1);
         chk("vec_cs_rise", cs_rise.size(), 1);
         if (gr_log.size() > 0) chk("vec_grant", gr_log[0], 1 << cur.r);
         if (wr_cyc.size() > 0 && cs_fall.size() > 0)
            chk("vec_setup", wr_cyc[0] - cs_fall[0], SETUP + 1);
         if (wr_cyc.size() == cur.exp_wr && cs_rise.size() > 0)
            chk("vec_cs_high", cs_rise[0] - wr_cyc[cur.exp_wr - 1], cur.rise_off);
         if (cur.exp_terr > 0 && cs_rise.size() > 0)
            chk("vec_terr_cyc", terr_cyc, cs_rise[0]);
         $display("vector %0d: req%0d bytes=%0d wr=%0d terr=%0d accepts=%0d", v, cur.r, cur.n, wr_log.size(), terr_n, acc_n);
      end

      // Both requesters contend: grants alternate with a GAP between frames.
      do_reset();
      done_lat = 2; level = 0; drop_idx = -1;
      load(0, 1, 32'h11); load(0, 1, 32'h12);
      load(1, 1, 32'h21); load(1, 1, 32'h22);
      exp2 = '{8'h11, 8'h21, 8'h12, 8'h22};
      wait_idle("alt_idle", 3000);
      chk("alt_wr_count", wr_log.size(), 4);
      chk("alt_frames", gr_log.size(), 4);
      for (int k = 0; k < 4 && k < wr_log.size() && k < gr_log.size(); k++) begin
         chk("alt_data", wr_log[k], exp2[k]);
         chk("alt_grant", gr_log[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      for (int k = 0; k < 3 && k + 1 < cs_fall.size() && k < cs_rise.size(); k++)
         chk("alt_gap", cs_fall[k + 1] - cs_rise[k], GAP + 1);
      chk("alt_viol", viol, 0);
      $display("alternate: frames=%0d wr=%0d", gr_log.size(), wr_log.size());

      // Requester stalls mid-frame for 100 cycles: frame stays open, no timeout.
      do_reset();
      done_lat = 3; level = 0; drop_idx = -1;
      load(0, 3, 32'h00C0B0A0);
      wait_wr("stall_first_wr", 1, 200);
      hold0 = 1;
      repeat (100) @(posedge clk);
      #1;
      chk("stall_cs_n", bus.spi_cs_n, 0);
      chk("stall_busy", bus.busy, 1);
      chk("stall_wr", wr_n, 1);
      chk("stall_acc", acc_n, 1);
      chk("stall_terr", terr_n, 0);
      hold0 = 0;
      wait_idle("stall_idle", 1000);
      chk("stall_wr_count", wr_log.size(), 3);
      if (wr_log.size() == 3) begin
         chk("stall_d1", wr_log[1], 8'hB0);
         chk("stall_d2", wr_log[2], 8'hC0);
      end
      chk("stall_terr_end", terr_n, 0);
      $display("stall: wr=%0d terr=%0d", wr_log.size(), terr_n);

      // Reset while waiting on the engine, then a clean frame.
      do_reset();
      done_lat = 3; level = 0; drop_idx = 0;
      load(0, 3, 32'h00030201);
      wait_wr("rstw_first_wr", 1, 200);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rstw_cs_n", bus.spi_cs_n, 1);
      chk("rstw_grant", bus.grant, 0);
      chk("rstw_busy", bus.busy, 0);
      q0.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("rstw_no_wr", wr_n, 1);
      rst = 1'b0;
      drop_idx = -1;
      clear_logs();
      load(0, 2, 32'h0000BBAA);
      wait_idle("rstw_idle", 1000);
      chk("rstw_wr_count", wr_log.size(), 2);
      if (wr_log.size() == 2) begin
         chk("rstw_d0", wr_log[0], 8'hAA);
         chk("rstw_d1", wr_log[1], 8'hBB);
      end
      if (gr_log.size() > 0) chk("rstw_grant_new", gr_log[0], 2'b01);
      chk("rstw_terr", terr_n, 0);
      $display("reset-in-wait: wr=%0d", wr_log.size());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
